// File: rtl/cache_ram_arbiter_if.sv
// cache_ram_arbiter_if: requester and RAM-side line-transfer signals of the cache/RAM arbiter
interface cache_ram_arbiter_if #(
  parameter int CASH_MEM_WIDTH = 128,
  parameter int ADDR_SIZE      = 14
);
  logic                      r0_aval;
  logic                      r0_wr;
  logic [ADDR_SIZE-1:0]      r0_addr;
  logic [CASH_MEM_WIDTH-1:0] r0_data_in;
  logic                      r0_ack;
  logic [CASH_MEM_WIDTH-1:0] r0_data_out;
  logic                      r1_aval;
  logic                      r1_wr;
  logic [ADDR_SIZE-1:0]      r1_addr;
  logic [CASH_MEM_WIDTH-1:0] r1_data_in;
  logic                      r1_ack;
  logic [CASH_MEM_WIDTH-1:0] r1_data_out;
  logic                      m_aval;
  logic                      m_wr;
  logic [ADDR_SIZE-1:0]      m_addr;
  logic [CASH_MEM_WIDTH-1:0] m_data_out;
  logic [CASH_MEM_WIDTH-1:0] m_data_in;
  logic                      m_ack;
  logic                      grant;
  logic                      busy;
  logic                      timeout_err;
  modport slave (
    input  r0_aval, r0_wr, r0_addr, r0_data_in, r1_aval, r1_wr, r1_addr, r1_data_in, m_data_in, m_ack,
    output r0_ack, r0_data_out, r1_ack, r1_data_out, m_aval, m_wr, m_addr, m_data_out, grant, busy, timeout_err
  );
  modport master (
    output r0_aval, r0_wr, r0_addr, r0_data_in, r1_aval, r1_wr, r1_addr, r1_data_in, m_data_in, m_ack,
    input  r0_ack, r0_data_out, r1_ack, r1_data_out, m_aval, m_wr, m_addr, m_data_out, grant, busy, timeout_err
  );
endinterface

// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter: round-robin sharing of one RAM line port between two cache requesters
module cache_ram_arbiter #(
  parameter int CASH_MEM_WIDTH = 128,
  parameter int ADDR_SIZE      = 14,
  parameter int TIMEOUT        = 255,
  parameter int TO_WIDTH       = 8
) (
  input logic                c_clk,
  input logic                c_reset,
  cache_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              state, nxt;
  logic                ptr;
  logic [1:0]          mask;
  logic [TO_WIDTH-1:0] cnt;
  logic                e0, e1, gnt_v, gnt_sel, to_hit, done;
  // decode: eligibility, grant choice and transaction completion
  always_comb begin
    e0      = bus.r0_aval && !mask[0];
    e1      = bus.r1_aval && !mask[1];
    gnt_v   = (state == IDLE) && (e0 || e1);
    gnt_sel = (e0 && e1) ? ptr : e1;
    to_hit  = cnt == TO_WIDTH'(TIMEOUT - 1);
    done    = (state == WAIT) && (bus.m_ack || to_hit);
  end
  // next-state selection
  always_comb begin
    nxt = (state == IDLE)  ? (gnt_v ? ISSUE : IDLE) :
          (state == ISSUE) ? WAIT :
          (state == WAIT)  ? (done ? RESP : WAIT) : IDLE;
  end
  // state register
  always_ff @(posedge c_clk) begin
    state <= c_reset ? IDLE : nxt;
  end
  // registered outputs, arbitration bookkeeping and watchdog
  always_ff @(posedge c_clk) begin
    if (c_reset) begin
      bus.m_aval      <= 1'b0;
      bus.m_wr        <= 1'b0;
      bus.m_addr      <= {ADDR_SIZE{1'b0}};
      bus.m_data_out  <= {CASH_MEM_WIDTH{1'b0}};
      bus.r0_ack      <= 1'b0;
      bus.r1_ack      <= 1'b0;
      bus.r0_data_out <= {CASH_MEM_WIDTH{1'b0}};
      bus.r1_data_out <= {CASH_MEM_WIDTH{1'b0}};
      bus.grant       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
      ptr             <= 1'b0;
      mask            <= 2'b00;
      cnt             <= '0;
    end else begin
      bus.m_aval <= gnt_v;
      bus.busy   <= nxt != IDLE;
      bus.r0_ack <= done && !bus.grant;
      bus.r1_ack <= done && bus.grant;
      mask       <= (state == RESP) ? {bus.grant, !bus.grant} : 2'b00;
      cnt        <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == RESP) ptr <= !bus.grant;
      if (gnt_v) begin
        bus.grant      <= gnt_sel;
        bus.m_wr       <= gnt_sel ? bus.r1_wr : bus.r0_wr;
        bus.m_addr     <= gnt_sel ? bus.r1_addr : bus.r0_addr;
        bus.m_data_out <= gnt_sel ? bus.r1_data_in : bus.r0_data_in;
      end
      if (done && !bus.m_ack) bus.timeout_err <= 1'b1;
      if (done && !bus.m_wr && !bus.grant) bus.r0_data_out <= bus.m_ack ? bus.m_data_in : {CASH_MEM_WIDTH{1'b0}};
      if (done && !bus.m_wr && bus.grant) bus.r1_data_out <= bus.m_ack ? bus.m_data_in : {CASH_MEM_WIDTH{1'b0}};
    end
  end
endmodule

// File: tb/tb_cache_ram_arbiter.sv
// tb_cache_ram_arbiter: directed scoreboard bench for the cache/RAM arbiter
module tb_cache_ram_arbiter;
  localparam int W = 128;
  localparam int A = 14;
  localparam logic [W-1:0] RD_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [W-1:0] WR_DATA = {16{8'hAA}};
  typedef struct {
    logic         port;
    logic [W-1:0] data;
  } exp_t;
  logic c_clk = 1'b0;
  logic c_reset = 1'b1;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int n;
  int acks;
  always #5 c_clk = ~c_clk;
  cache_ram_arbiter_if #(.CASH_MEM_WIDTH(W), .ADDR_SIZE(A)) bus ();
  cache_ram_arbiter #(.CASH_MEM_WIDTH(W), .ADDR_SIZE(A), .TIMEOUT(8), .TO_WIDTH(8)) dut (
    .c_clk(c_clk),
    .c_reset(c_reset),
    .bus(bus)
  );
  task automatic step();
    @(negedge c_clk);
  endtask
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_maval(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.m_aval && cyc < 40);
    chk("m_aval_seen", bus.m_aval, 1);
  endtask
  task automatic expect_resp(output int cyc);
    exp_t e;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(bus.r0_ack || bus.r1_ack) && cyc < 40);
    chk("ack_seen", bus.r0_ack || bus.r1_ack, 1);
    chk("sb_nonempty", sb.size() > 0, 1);
    if ((bus.r0_ack || bus.r1_ack) && sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_port", bus.r1_ack, e.port);
      chk("resp_data", e.port ? bus.r1_data_out : bus.r0_data_out, e.data);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_aval"}, bus.m_aval, 0);
    chk({tag, "_m_wr"}, bus.m_wr, 0);
    chk({tag, "_m_addr"}, bus.m_addr, 0);
    chk({tag, "_m_data_out"}, bus.m_data_out, 0);
    chk({tag, "_r0_ack"}, bus.r0_ack, 0);
    chk({tag, "_r1_ack"}, bus.r1_ack, 0);
    chk({tag, "_r0_data_out"}, bus.r0_data_out, 0);
    chk({tag, "_r1_data_out"}, bus.r1_data_out, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask
  initial begin
    bus.r0_aval = 0; bus.r0_wr = 0; bus.r0_addr = '0; bus.r0_data_in = '0;
    bus.r1_aval = 0; bus.r1_wr = 0; bus.r1_addr = '0; bus.r1_data_in = '0;
    bus.m_data_in = '0; bus.m_ack = 0;
    step(); step();
    chk_all_zero("reset");
    c_reset = 0;
    step();
    // single read on req 0
    bus.r0_wr = 0; bus.r0_addr = 14'h0A5; bus.r0_aval = 1;
    wait_maval(n);
    chk("rd_maval_lat", n, 1);
    chk("rd_m_addr", bus.m_addr, 14'h0A5);
    chk("rd_m_wr", bus.m_wr, 0);
    chk("rd_grant", bus.grant, 0);
    chk("rd_busy", bus.busy, 1);
    sb.push_back('{1'b0, RD_DATA});
    step();
    chk("rd_maval_pulse", bus.m_aval, 0);
    step(); step(); step();
    bus.m_ack = 1; bus.m_data_in = RD_DATA;
    expect_resp(n);
    chk("rd_ack_lat", n, 1);
    bus.m_ack = 0; bus.r0_aval = 0;
    step();
    chk("rd_busy_after", bus.busy, 0);
    chk("rd_ack_pulse", bus.r0_ack, 0);
    // single write on req 1
    bus.r1_wr = 1; bus.r1_addr = 14'h3FFF; bus.r1_data_in = WR_DATA; bus.r1_aval = 1;
    wait_maval(n);
    chk("wr_m_wr", bus.m_wr, 1);
    chk("wr_m_addr", bus.m_addr, 14'h3FFF);
    chk("wr_m_data", bus.m_data_out, WR_DATA);
    chk("wr_grant", bus.grant, 1);
    sb.push_back('{1'b1, '0});
    step();
    bus.r1_addr = 14'h0001; bus.r1_data_in = '0;
    step();
    bus.m_ack = 1; bus.m_data_in = RD_DATA;
    expect_resp(n);
    chk("wr_m_addr_resp", bus.m_addr, 14'h3FFF);
    chk("wr_m_data_resp", bus.m_data_out, WR_DATA);
    bus.m_ack = 0; bus.r1_aval = 0;
    step();
    chk("wr_m_addr_idle", bus.m_addr, 14'h3FFF);
    chk("wr_m_wr_idle", bus.m_wr, 1);
    // contention: both requesters held high, round-robin order expected
    bus.r0_wr = 0; bus.r0_addr = 14'h0001; bus.r1_wr = 0; bus.r1_addr = 14'h0002;
    bus.r0_aval = 1; bus.r1_aval = 1;
    for (int i = 0; i < 4; i++) begin
      wait_maval(n);
      chk("rr_gap", n, (i == 0) ? 1 : 2);
      chk("rr_grant", bus.grant, (i % 2 == 1) ? 1 : 0);
      chk("rr_m_addr", bus.m_addr, (i % 2 == 1) ? 14'h0002 : 14'h0001);
      sb.push_back('{(i % 2 == 1), {64'(i + 1), 64'hC0DE}});
      step();
      bus.m_ack = 1; bus.m_data_in = {64'(i + 1), 64'hC0DE};
      expect_resp(n);
      chk("rr_ack_lat", n, 1);
      bus.m_ack = 0;
    end
    bus.r0_aval = 0; bus.r1_aval = 0;
    step();
    // mask: req 0 keeps aval high past its ack
    bus.r0_addr = 14'h0055; bus.r0_aval = 1;
    wait_maval(n);
    sb.push_back('{1'b0, {64'h55, 64'h1}});
    step();
    bus.m_ack = 1; bus.m_data_in = {64'h55, 64'h1};
    expect_resp(n);
    bus.m_ack = 0;
    wait_maval(n);
    chk("mask_gap", n, 3);
    chk("mask_grant", bus.grant, 0);
    sb.push_back('{1'b0, {64'h55, 64'h2}});
    step();
    bus.m_ack = 1; bus.m_data_in = {64'h55, 64'h2};
    expect_resp(n);
    bus.m_ack = 0; bus.r0_aval = 0;
    step();
    // watchdog timeout on a read with no downstream ack
    bus.m_data_in = '1; bus.r0_aval = 1;
    wait_maval(n);
    sb.push_back('{1'b0, '0});
    expect_resp(n);
    chk("to_ack_lat", n, 9);
    chk("to_err", bus.timeout_err, 1);
    bus.r0_aval = 0;
    step();
    bus.m_ack = 1;
    step();
    chk("late_ack_busy", bus.busy, 0);
    chk("late_ack_r0_ack", bus.r0_ack, 0);
    step();
    chk("to_err_sticky", bus.timeout_err, 1);
    chk("late_ack_data", bus.r0_data_out, 0);
    bus.m_ack = 0;
    // reset in the middle of WAIT
    bus.r1_wr = 1; bus.r1_addr = 14'h1234; bus.r1_data_in = WR_DATA; bus.r1_aval = 1;
    wait_maval(n);
    step();
    chk("mid_busy", bus.busy, 1);
    c_reset = 1;
    step();
    chk_all_zero("mid_reset");
    c_reset = 0; bus.r1_aval = 0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acks += int'(bus.r0_ack) + int'(bus.r1_ack);
    end
    chk("mid_reset_no_ack", acks, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
